data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle, byte-addressable data memory for an RV32I Mem stage.
// Define DM_MISALIGN_CHECK_EN to flag and suppress misaligned halfword/word accesses.
module data_mem_ctrl #(
   parameter int unsigned DM_MEM_DEPTH = 4096,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned FUNC3_WIDTH  = 3,
   parameter int unsigned WAIT_CYCLES  = 2
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   memRead,
   input  logic                   memWrite,
   input  logic [FUNC3_WIDTH-1:0] func3,
   input  logic [DATA_WIDTH-1:0]  address,
   input  logic [DATA_WIDTH-1:0]  writeData,
   output logic [DATA_WIDTH-1:0]  readData,
   output logic                   memReady,
   output logic                   misaligned
);

   localparam int unsigned IDX_W = (DM_MEM_DEPTH > 1) ? $clog2(DM_MEM_DEPTH) : 1;
   localparam int unsigned WA_W  = DATA_WIDTH - 2;

   localparam logic [FUNC3_WIDTH-1:0] F3_B  = FUNC3_WIDTH'(3'b000);
   localparam logic [FUNC3_WIDTH-1:0] F3_H  = FUNC3_WIDTH'(3'b001);
   localparam logic [FUNC3_WIDTH-1:0] F3_W  = FUNC3_WIDTH'(3'b010);
   localparam logic [FUNC3_WIDTH-1:0] F3_BU = FUNC3_WIDTH'(3'b100);
   localparam logic [FUNC3_WIDTH-1:0] F3_HU = FUNC3_WIDTH'(3'b101);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [FUNC3_WIDTH-1:0]  f3_q, f3_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    is_wr_q, is_wr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    ready_q, ready_d;
   logic                    mis_q, mis_d;

   logic [31:0]             mem [DM_MEM_DEPTH];

   logic [FUNC3_WIDTH-1:0]  acc_f3;
   logic [DATA_WIDTH-1:0]   acc_addr;
   logic [DATA_WIDTH-1:0]   acc_wdata;
   logic                    acc_wr;
   logic                    acc_mis;
   logic [WA_W-1:0]         word_addr;
   logic [IDX_W-1:0]        idx;
   logic [1:0]              lane;
   logic [31:0]             word_rd;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [31:0]             load_val;
   logic [3:0]              be;
   logic [31:0]             wbytes;
   logic                    commit;
   logic                    mem_we;

   // With WAIT_CYCLES=0 the access commits straight from IDLE, before anything is latched,
   // so the access fields come from the live inputs in IDLE and from the latches otherwise.
   always_comb begin
      if (state_q == IDLE) begin
         acc_f3    = func3;
         acc_addr  = address;
         acc_wdata = writeData;
         acc_wr    = memWrite;
      end else begin
         acc_f3    = f3_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_wr    = is_wr_q;
      end
   end

   assign word_addr = acc_addr[DATA_WIDTH-1:2];
   assign idx       = IDX_W'(word_addr % WA_W'(DM_MEM_DEPTH));
   assign lane      = acc_addr[1:0];
   assign word_rd   = mem[idx];

   always_comb begin
      byte_sel = word_rd[{lane, 3'b000} +: 8];
      half_sel = acc_addr[1] ? word_rd[31:16] : word_rd[15:0];
      acc_mis  = 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
      if ((acc_f3 == F3_H) || (acc_f3 == F3_HU)) begin
         acc_mis = acc_addr[0];
      end else if (acc_f3 == F3_W) begin
         acc_mis = |acc_addr[1:0];
      end
`endif
      load_val = '0;
      be       = '0;
      wbytes   = '0;
      case (acc_f3)
         F3_B: begin
            load_val = {{24{byte_sel[7]}}, byte_sel};
            be       = 4'b0001 << lane;
            wbytes   = {4{acc_wdata[7:0]}};
         end
         F3_H: begin
            load_val = {{16{half_sel[15]}}, half_sel};
            be       = acc_addr[1] ? 4'b1100 : 4'b0011;
            wbytes   = {2{acc_wdata[15:0]}};
         end
         F3_W: begin
            load_val = word_rd;
            be       = 4'b1111;
            wbytes   = acc_wdata[31:0];
         end
         F3_BU: load_val = {24'h0, byte_sel};
         F3_HU: load_val = {16'h0, half_sel};
         default: ;
      endcase
      if (acc_mis) begin
         be       = '0;
         load_val = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      mis_d   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (memRead || memWrite) begin
               f3_d    = func3;
               addr_d  = address;
               wdata_d = writeData;
               is_wr_d = memWrite;
               if (WAIT_CYCLES == 0) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         WAIT: begin
            if (!memRead && !memWrite) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = DONE;
                  commit  = 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (commit) begin
         ready_d = 1'b1;
         mis_d   = acc_mis;
         if (!acc_wr) begin
            rdata_d = DATA_WIDTH'(load_val);
         end
      end
   end

   // Gated by rstN so a WAIT_CYCLES=0 store presented while reset is held cannot commit.
   assign mem_we = commit && acc_wr && rstN;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wbytes[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         mis_q   <= mis_d;
      end
   end

   assign readData = rdata_q;
   assign memReady = ready_q;
`ifdef DM_MISALIGN_CHECK_EN
   assign misaligned = mis_q;
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: WAIT_CYCLES=2 instance for the main vectors,
// WAIT_CYCLES=0 instance for the back-to-back held-request case.
module tb_data_mem_ctrl;

   typedef struct {
      int unsigned cyc;
      logic [31:0] rd;
      logic        mis;
      string       name;
   } exp_t;

   logic        clk;
   logic        rstN;
   int unsigned cyc;
   int unsigned checks;
   int unsigned errors;

   logic        memRead, memWrite;
   logic [2:0]  func3;
   logic [31:0] address, writeData, readData;
   logic        memReady, misaligned;

   logic        memRead1, memWrite1;
   logic [2:0]  func3_1;
   logic [31:0] address1, writeData1, readData1;
   logic        memReady1, misaligned1;

   exp_t q0[$];
   exp_t q1[$];
   exp_t m0, m1;

   data_mem_ctrl #(
      .DM_MEM_DEPTH(4096),
      .DATA_WIDTH  (32),
      .FUNC3_WIDTH (3),
      .WAIT_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rstN      (rstN),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .func3     (func3),
      .address   (address),
      .writeData (writeData),
      .readData  (readData),
      .memReady  (memReady),
      .misaligned(misaligned)
   );

   data_mem_ctrl #(
      .DM_MEM_DEPTH(4096),
      .DATA_WIDTH  (32),
      .FUNC3_WIDTH (3),
      .WAIT_CYCLES (0)
   ) dut0w (
      .clk       (clk),
      .rstN      (rstN),
      .memRead   (memRead1),
      .memWrite  (memWrite1),
      .func3     (func3_1),
      .address   (address1),
      .writeData (writeData1),
      .readData  (readData1),
      .memReady  (memReady1),
      .misaligned(misaligned1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (memReady === 1'b1) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready_w2: memReady=1 at cycle %0d, expected 0", cyc);
         end else begin
            m0 = q0.pop_front();
            chk({m0.name, "_cycle"}, 32'(cyc), 32'(m0.cyc));
            chk({m0.name, "_rdata"}, readData, m0.rd);
            chk({m0.name, "_misaligned"}, {31'b0, misaligned}, {31'b0, m0.mis});
         end
      end
   end

   always @(negedge clk) begin
      if (memReady1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready_w0: memReady=1 at cycle %0d, expected 0", cyc);
         end else begin
            m1 = q1.pop_front();
            chk({m1.name, "_cycle"}, 32'(cyc), 32'(m1.cyc));
            chk({m1.name, "_rdata"}, readData1, m1.rd);
            chk({m1.name, "_misaligned"}, {31'b0, misaligned1}, {31'b0, m1.mis});
         end
      end
   end

   // Issued at #1 after a rising edge while the DUT is in IDLE; returns in the next IDLE cycle.
   task automatic access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis);
      exp_t e;
      int unsigned n;
      e.cyc  = cyc + 3;
      e.rd   = exp_rd;
      e.mis  = exp_mis;
      e.name = name;
      q0.push_back(e);
      memRead   = rd;
      memWrite  = wr;
      func3     = f3;
      address   = a;
      writeData = wd;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (memReady !== 1'b1 && n < 20);
      memRead  = 1'b0;
      memWrite = 1'b0;
      if (memReady !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: memReady=%b after %0d cycles, expected 1", name, memReady, n);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      exp_t e;
      int unsigned s;
      checks     = 0;
      errors     = 0;
      rstN       = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      func3      = 3'b000;
      address    = '0;
      writeData  = '0;
      memRead1   = 1'b0;
      memWrite1  = 1'b0;
      func3_1    = 3'b000;
      address1   = '0;
      writeData1 = '0;
      #1;
      chk("reset_rdata", readData, 32'h0);
      chk("reset_ready", {31'b0, memReady}, 32'h0);
      chk("reset_misaligned", {31'b0, misaligned}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      while (cyc < 5) begin
         @(posedge clk);
         #1;
      end

      access("sw_10",      1'b0, 1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0);
      access("lw_10",      1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0);
      access("lb_13",      1'b1, 1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0);
      access("lbu_13",     1'b1, 1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0);
      access("lh_12",      1'b1, 1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0);
      access("lhu_10",     1'b1, 1'b0, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 1'b0);
      access("sb_11",      1'b0, 1'b1, 3'b000, 32'h11,   32'hAAAAAA55, 32'h0000BEEF, 1'b0);
      access("lw_10_sb",   1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0);
      access("sw_14",      1'b0, 1'b1, 3'b010, 32'h14,   32'h11223344, 32'hDEAD55EF, 1'b0);
      access("sh_16",      1'b0, 1'b1, 3'b001, 32'h16,   32'hFFFFCAFE, 32'hDEAD55EF, 1'b0);
      access("lw_14",      1'b1, 1'b0, 3'b010, 32'h14,   32'h0,        32'hCAFE3344, 1'b0);
      access("sw_4000",    1'b0, 1'b1, 3'b010, 32'h4000, 32'h0BADF00D, 32'hCAFE3344, 1'b0);
      access("lw_0_wrap",  1'b1, 1'b0, 3'b010, 32'h0,    32'h0,        32'h0BADF00D, 1'b0);
      access("rdwr_20",    1'b1, 1'b1, 3'b010, 32'h20,   32'h87654321, 32'h0BADF00D, 1'b0);
      access("lw_20",      1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        32'h87654321, 1'b0);
      access("f3_011_wr",  1'b0, 1'b1, 3'b011, 32'h20,   32'h0,        32'h87654321, 1'b0);
      access("f3_011_rd",  1'b1, 1'b0, 3'b011, 32'h20,   32'h0,        32'h00000000, 1'b0);
      access("lw_20_b",    1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        32'h87654321, 1'b0);

      // Store aborted by dropping memWrite after one WAIT cycle.
      memWrite  = 1'b1;
      func3     = 3'b010;
      address   = 32'h20;
      writeData = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      memWrite = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      access("lw_20_abort", 1'b1, 1'b0, 3'b010, 32'h20,  32'h0,        32'h87654321, 1'b0);

`ifdef DM_MISALIGN_CHECK_EN
      access("sw_12_mis",  1'b0, 1'b1, 3'b010, 32'h12,   32'h0,        32'h87654321, 1'b1);
      access("lw_10_mis",  1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0);
      access("lh_11_mis",  1'b1, 1'b0, 3'b001, 32'h11,   32'h0,        32'h00000000, 1'b1);
`else
      access("lw_12",      1'b1, 1'b0, 3'b010, 32'h12,   32'h0,        32'hDEAD55EF, 1'b0);
      access("lh_13",      1'b1, 1'b0, 3'b001, 32'h13,   32'h0,        32'hFFFFDEAD, 1'b0);
`endif
      access("lb_11",      1'b1, 1'b0, 3'b000, 32'h11,   32'h0,        32'h00000055, 1'b0);

      // Reset asserted mid-WAIT: store must not land, readData clears.
      memWrite  = 1'b1;
      func3     = 3'b010;
      address   = 32'h10;
      writeData = 32'h0;
      @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      chk("rst_wait_rdata", readData, 32'h0);
      chk("rst_wait_ready", {31'b0, memReady}, 32'h0);
      memWrite = 1'b0;
      @(posedge clk);
      #1;
      rstN = 1'b1;
      @(posedge clk);
      #1;
      access("lw_10_rst",  1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0);

      // WAIT_CYCLES=0 instance: store, then a read held for four cycles.
      s = cyc;
      e.cyc = s + 1; e.rd = 32'h0; e.mis = 1'b0; e.name = "w0_sw_8";
      q1.push_back(e);
      memWrite1  = 1'b1;
      func3_1    = 3'b010;
      address1   = 32'h8;
      writeData1 = 32'h5A5A5A5A;
      @(posedge clk);
      #1;
      memWrite1 = 1'b0;
      @(posedge clk);
      #1;
      s = cyc;
      e.cyc = s + 1; e.rd = 32'h5A5A5A5A; e.mis = 1'b0; e.name = "w0_lw_8_a";
      q1.push_back(e);
      e.cyc = s + 3; e.rd = 32'h5A5A5A5A; e.mis = 1'b0; e.name = "w0_lw_8_b";
      q1.push_back(e);
      memRead1 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      memRead1 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      chk("w2_queue_drained", 32'(q0.size()), 32'h0);
      chk("w0_queue_drained", 32'(q1.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
